// File: rtl/ddr_wr_pattern_gen.sv
// Row-by-row DDR write fill generator: requests one burst per row from ddr2_mgr and streams a pattern dword per accepted beat.
// Optional feature macro DDR_WR_PATTERN_INCR_EN: wr_data = {9'h000, row, word_cnt} instead of the constant DWORD_PRELOAD.
module ddr_wr_pattern_gen #(
    parameter logic [9:0]  XFR_LEN_PER_LINE = 10'h200,
    parameter logic [31:0] DWORD_PRELOAD    = 32'hA5A5_5A5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [12:0] base_row,
    input  logic [12:0] num_lines,
    output logic        wr_mem_req,
    output logic [24:0] wr_mem_addr,
    output logic [9:0]  wr_xfr_len,
    input  logic        wr_mem_grant,
    input  logic        wr_data_req,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [12:0] line_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFR  = 2'd2,
        NEXT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [12:0] row_q, row_d;
    logic [12:0] lines_left_q, lines_left_d;
    logic [12:0] line_cnt_q, line_cnt_d;
    logic [9:0]  word_cnt_q, word_cnt_d;
    logic        wr_mem_req_q, wr_mem_req_d;
    logic [24:0] wr_mem_addr_q, wr_mem_addr_d;
    logic [9:0]  wr_xfr_len_q, wr_xfr_len_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Request handshake: wr_mem_req with its addr/len is held stable until the
    // first cycle wr_mem_grant=1 is seen in REQ; the request drops on the next
    // cycle. Each wr_data_req=1 cycle in XFR consumes the wr_data shown that
    // cycle, and the next dword appears one cycle later.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        lines_left_d  = lines_left_q;
        line_cnt_d    = line_cnt_q;
        word_cnt_d    = word_cnt_q;
        wr_mem_req_d  = wr_mem_req_q;
        wr_mem_addr_d = wr_mem_addr_q;
        wr_xfr_len_d  = wr_xfr_len_q;
        wr_data_d     = wr_data_q;
        done_d        = done_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_lines != 13'd0) begin
                        row_d         = base_row;
                        lines_left_d  = num_lines;
                        line_cnt_d    = 13'd0;
                        done_d        = 1'b0;
                        wr_mem_req_d  = 1'b1;
                        wr_mem_addr_d = {base_row, 10'h000, 2'b00};
                        wr_xfr_len_d  = XFR_LEN_PER_LINE;
                        state_d       = REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (wr_mem_grant) begin
                    wr_mem_req_d = 1'b0;
                    word_cnt_d   = 10'd0;
                    state_d      = XFR;
`ifdef DDR_WR_PATTERN_INCR_EN
                    wr_data_d    = {9'h000, row_q, 10'd0};
`endif
                end
            end
            XFR: begin
                if (wr_data_req) begin
                    word_cnt_d = word_cnt_q + 10'd1;
`ifdef DDR_WR_PATTERN_INCR_EN
                    wr_data_d  = {9'h000, row_q, word_cnt_d};
`endif
                    if (word_cnt_q == XFR_LEN_PER_LINE - 10'd1) begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                // Row address wraps naturally at 13 bits.
                row_d        = row_q + 13'd1;
                line_cnt_d   = line_cnt_q + 13'd1;
                lines_left_d = lines_left_q - 13'd1;
                if (lines_left_q == 13'd1) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wr_mem_req_d  = 1'b1;
                    wr_mem_addr_d = {row_d, 10'h000, 2'b00};
                    wr_xfr_len_d  = XFR_LEN_PER_LINE;
                    state_d       = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifndef DDR_WR_PATTERN_INCR_EN
        wr_data_d = DWORD_PRELOAD;
`endif
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            row_q         <= 13'd0;
            lines_left_q  <= 13'd0;
            line_cnt_q    <= 13'd0;
            word_cnt_q    <= 10'd0;
            wr_mem_req_q  <= 1'b0;
            wr_mem_addr_q <= 25'd0;
            wr_xfr_len_q  <= 10'd0;
            wr_data_q     <= DWORD_PRELOAD;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            lines_left_q  <= lines_left_d;
            line_cnt_q    <= line_cnt_d;
            word_cnt_q    <= word_cnt_d;
            wr_mem_req_q  <= wr_mem_req_d;
            wr_mem_addr_q <= wr_mem_addr_d;
            wr_xfr_len_q  <= wr_xfr_len_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign wr_mem_req  = wr_mem_req_q;
    assign wr_mem_addr = wr_mem_addr_q;
    assign wr_xfr_len  = wr_xfr_len_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign line_cnt    = line_cnt_q;

endmodule

// File: tb/tb_ddr_wr_pattern_gen.sv
// Directed bench for ddr_wr_pattern_gen: expected request addresses queued at start, popped as requests appear.
module tb_ddr_wr_pattern_gen;

    localparam logic [9:0]  LEN     = 10'h200;
    localparam logic [31:0] PRELOAD = 32'hA5A5_5A5A;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        start        = 1'b0;
    logic [12:0] base_row     = 13'd0;
    logic [12:0] num_lines    = 13'd0;
    logic        wr_mem_grant = 1'b0;
    logic        wr_data_req  = 1'b0;
    logic        wr_mem_req;
    logic [24:0] wr_mem_addr;
    logic [9:0]  wr_xfr_len;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [12:0] line_cnt;

    int total = 0;
    int bad = 0;
    int req_rises = 0;
    int exp_rises = 0;
    logic req_prev = 1'b0;
    logic [24:0] exp_q[$];

    always #5 clk = ~clk;

    ddr_wr_pattern_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_row     (base_row),
        .num_lines    (num_lines),
        .wr_mem_req   (wr_mem_req),
        .wr_mem_addr  (wr_mem_addr),
        .wr_xfr_len   (wr_xfr_len),
        .wr_mem_grant (wr_mem_grant),
        .wr_data_req  (wr_data_req),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .line_cnt     (line_cnt)
    );

    // Counts every new request so spurious requests show up at the end.
    always @(negedge clk) begin
        if (wr_mem_req === 1'b1 && req_prev !== 1'b1) req_rises++;
        req_prev = wr_mem_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called right after a negedge; returns one negedge after the start pulse.
    task automatic start_fill(input logic [12:0] b, input logic [12:0] n);
        logic [12:0] r;
        r = b;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({r, 10'h000, 2'b00});
            r = r + 13'd1;
        end
        exp_rises += int'(n);
        start = 1'b1;
        base_row = b;
        num_lines = n;
        @(negedge clk);
        start = 1'b0;
        if (n != 13'd0) begin
            chk("start_busy", busy, 1);
            chk("start_req", wr_mem_req, 1);
            chk("start_done_clr", done, 0);
            chk("start_line_cnt", line_cnt, 0);
        end else begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            chk("zero_req", wr_mem_req, 0);
        end
    endtask

    // Serves one row request: grant after gdel cycles, then 512 accepted beats.
    task automatic serve_row(input int gdel, input bit cont, input bit stray_start,
                             input bit last_row, input logic [12:0] exp_lines);
        int guard;
        int k;
        int cyc;
        logic dr;
        logic [24:0] ea;
        logic [31:0] ew;
        guard = 0;
        k = 0;
        cyc = 0;
        wr_data_req = cont;
        while (wr_mem_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("req_wait", wr_mem_req, 1);
        if (exp_q.size() != 0) ea = exp_q.pop_front();
        else ea = '1;
        chk("req_addr", wr_mem_addr, ea);
        chk("req_len", wr_xfr_len, LEN);
        for (int i = 0; i < gdel; i++) begin
            if (stray_start && i == 0) begin
                start = 1'b1;
                base_row = 13'h0ABC;
                num_lines = 13'd7;
            end
            @(negedge clk);
            start = 1'b0;
            chk("req_hold", wr_mem_req, 1);
            chk("addr_hold", wr_mem_addr, ea);
        end
        wr_mem_grant = 1'b1;
        @(negedge clk);
        wr_mem_grant = 1'b0;
        chk("req_drop", wr_mem_req, 0);
        chk("busy_xfr", busy, 1);
        while (k < int'(LEN) && cyc < 4 * int'(LEN)) begin
            dr = cont ? 1'b1 : (cyc % 2 == 0);
            wr_data_req = dr;
            if (dr) begin
`ifdef DDR_WR_PATTERN_INCR_EN
                logic [9:0] kw;
                kw = k[9:0];
                ew = {9'h000, ea[24:12], kw};
`else
                ew = PRELOAD;
`endif
                chk("wdata", wr_data, ew);
            end
            @(negedge clk);
            if (dr) k++;
            cyc++;
        end
        wr_data_req = cont;
        chk("next_no_req", wr_mem_req, 0);
        chk("next_busy", busy, 1);
        @(negedge clk);
        if (last_row) begin
            chk("end_done", done, 1);
            chk("end_busy", busy, 0);
            chk("end_req", wr_mem_req, 0);
        end else begin
            chk("next_row_req", wr_mem_req, 1);
            chk("mid_done", done, 0);
        end
        chk("line_cnt", line_cnt, exp_lines);
    endtask

    initial begin
        int seen;
        logic [24:0] ea;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", wr_mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_line_cnt", line_cnt, 0);
        chk("rst_addr", wr_mem_addr, 0);
        chk("rst_len", wr_xfr_len, 0);
        chk("rst_wdata", wr_data, PRELOAD);
        rst_n = 1'b1;
        @(negedge clk);

        // zero-line fill: done right away, no request
        start_fill(13'h0033, 13'd0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wr_mem_req !== 1'b0) seen++;
        end
        chk("zero_no_req", seen, 0);
        chk("zero_done_hold", done, 1);

        // single row, grant 3 cycles late, continuous data request
        start_fill(13'd5, 13'd1);
        serve_row(3, 1'b1, 1'b0, 1'b1, 13'd1);
        wr_data_req = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("done_sticky", done, 1);
        chk("idle_line_cnt", line_cnt, 1);

        // row wrap 1FFE -> 1FFF -> 0000
        start_fill(13'h1FFE, 13'd3);
        serve_row(0, 1'b1, 1'b0, 1'b0, 13'd1);
        serve_row(1, 1'b1, 1'b0, 1'b0, 13'd2);
        serve_row(0, 1'b1, 1'b0, 1'b1, 13'd3);
        wr_data_req = 1'b0;
        @(negedge clk);

        // toggled data request
        start_fill(13'h0100, 13'd2);
        serve_row(2, 1'b0, 1'b0, 1'b0, 13'd1);
        serve_row(1, 1'b0, 1'b0, 1'b1, 13'd2);
        @(negedge clk);

        // start pulsed while busy, data request while waiting for grant
        start_fill(13'h0020, 13'd1);
        serve_row(3, 1'b1, 1'b1, 1'b1, 13'd1);
        wr_data_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wr_mem_req !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("stray_start_idle", seen, 0);

        // reset during transfer of the second row
        start_fill(13'd10, 13'd3);
        serve_row(0, 1'b1, 1'b0, 1'b0, 13'd1);
        wr_data_req = 1'b1;
        chk("rst_row2_req", wr_mem_req, 1);
        ea = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        chk("rst_row2_addr", wr_mem_addr, ea);
        wr_mem_grant = 1'b1;
        @(negedge clk);
        wr_mem_grant = 1'b0;
        for (int i = 0; i < 100; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", wr_mem_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_line_cnt", line_cnt, 0);
        chk("mid_rst_addr", wr_mem_addr, 0);
        chk("mid_rst_len", wr_xfr_len, 0);
        chk("mid_rst_wdata", wr_data, PRELOAD);
        exp_q.delete();
        exp_rises -= 1;
        wr_data_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_data_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_mem_req !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("post_rst_quiet", seen, 0);
        wr_data_req = 1'b0;

        // recovery fill after reset
        start_fill(13'd7, 13'd1);
        serve_row(2, 1'b0, 1'b0, 1'b1, 13'd1);
        @(negedge clk);

        chk("req_count", req_rises, exp_rises);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_wr_pattern_gen.md
DDR_WR_PATTERN_GEN -- requirements
Module: ddr_wr_pattern_gen

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- XFR_LEN_PER_LINE, 10'h200, dwords per row burst request.
- DWORD_PRELOAD, 32'hA5A5_5A5A, fixed fill word.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, single clock; all logic on posedge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that begins a fill.
- base_row, in, 13, first row to write.
- num_lines, in, 13, number of rows to write.
- wr_mem_req, out, 1, write request to ddr2_mgr.
- wr_mem_addr, out, 25, {row[12:0], col[9:0], bank[1:0]}.
- wr_xfr_len, out, 10, dwords in the request.
- wr_mem_grant, in, 1, request accepted.
- wr_data_req, in, 1, ddr2_mgr consumes wr_data this cycle.
- wr_data, out, 32, write dword.
- busy, out, 1, fill in progress.
- done, out, 1, sticky fill-complete flag.
- line_cnt, out, 13, rows completed in the current fill.

Function
REQ-003 The FSM SHALL have four states: IDLE, REQ, XFR, NEXT.
REQ-004 In IDLE, start=1 with num_lines!=0 SHALL capture row=base_row and lines_left=num_lines, clear done and line_cnt, and enter REQ next cycle.
REQ-005 In IDLE, start=1 with num_lines==0 SHALL set done=1 and stay in IDLE without asserting wr_mem_req.
REQ-006 start SHALL be ignored in every state other than IDLE.
REQ-007 In REQ, wr_mem_req SHALL be 1, wr_mem_addr={row,10'h0,2'b00} and wr_xfr_len=XFR_LEN_PER_LINE, all held stable until grant.
REQ-008 wr_mem_grant=1 in REQ SHALL deassert wr_mem_req on the next cycle, clear word_cnt, and enter XFR.
REQ-009 In XFR, each cycle with wr_data_req=1 SHALL increment word_cnt by 1, and wr_data SHALL reflect the new word_cnt on the following cycle.
REQ-010 wr_data_req=1 with word_cnt==XFR_LEN_PER_LINE-1 SHALL enter NEXT.
REQ-011 wr_data_req SHALL be ignored outside XFR, with no counter change.
REQ-012 In NEXT (one cycle), the block SHALL:
- increment row modulo 2^13 (13'h1FFF wraps to 0);
- increment line_cnt;
- decrement lines_left.
REQ-013 From NEXT, the FSM SHALL go to IDLE with done=1 if lines_left was 1; otherwise it SHALL go to REQ.
REQ-014 busy SHALL equal (state!=IDLE).
REQ-015 done SHALL stay high until the next accepted start.
REQ-016 All outputs SHALL be registered, and no combinational path SHALL exist from any input to any output.

Reset
REQ-017 rst_n=0 SHALL asynchronously force:
- state=IDLE;
- wr_mem_req=0, busy=0, done=0;
- line_cnt=0, row=0, word_cnt=0;
- wr_xfr_len=0, wr_mem_addr=0;
- wr_data=DWORD_PRELOAD.
REQ-018 Reset asserted mid-fill SHALL abandon the fill, and no request SHALL be issued after rst_n deasserts until a new start.

Configuration
REQ-019 With DDR_WR_PATTERN_INCR_EN defined, wr_data SHALL be {9'h000, row, word_cnt}.
REQ-020 Without DDR_WR_PATTERN_INCR_EN, wr_data SHALL be constant DWORD_PRELOAD, matching the read checker.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- start, base_row=5, num_lines=1, grant 3 cycles after req, wr_data_req continuous -> one req with addr={13'd5,10'h0,2'b0} and len 10'h200; 512 words; done=1; line_cnt=1.
- base_row=13'h1FFE, num_lines=3 -> requests to rows 1FFE, 1FFF, 0000; line_cnt=3.
- wr_data_req toggled 1/0 -> exactly 512 words accepted per row; with INCR_EN, wr_data sequence 0..511 in low 10 bits, no skips or repeats.
- num_lines=0 -> done=1 the cycle after start; wr_mem_req never asserted.
- start pulsed while busy, plus wr_data_req while in REQ -> both ignored; row and word counts unchanged.
- rst_n low during XFR of row 2 -> all outputs at reset values immediately; no wr_mem_req after release until start.
